// File: rtl/kp_pkg.sv
// kp_pkg: shared types, event layout and helpers for the keypad scanner.
// Holds FSM encoding, event flag offsets and the clog2 helper.
package kp_pkg;

   typedef enum logic [1:0] {
      DRIVE  = 2'd0,
      SAMPLE = 2'd1,
      UPDATE = 2'd2
   } state_t;

   // Event word = {flags, index}; flag bits sit above the index field.
   localparam int EV_FLAG_W = 2;
   localparam int EV_REPEAT = 1;
   localparam int EV_PRESS  = 0;

   function automatic int kp_clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

   // Width of the key index field for n keys.
   function automatic int ev_idx_w(input int n);
      return (n < 2) ? 1 : kp_clog2(n);
   endfunction

endpackage

// File: rtl/kp_event_fifo.sv
// kp_event_fifo: first-word-fall-through event FIFO, drop-on-full + sticky ovf.
// Ports: clk, rst, push/push_data, ovf_clr, ready (pop), valid, data, ovf.
module kp_event_fifo
   import kp_pkg::*;
#(
   parameter int W     = 6,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         ovf_clr,
   input  logic         ready,
   output logic         valid,
   output logic [W-1:0] data,
   output logic         ovf
);

   localparam int AW = kp_clog2(DEPTH);

   logic [W-1:0] mem [DEPTH];
   logic [AW:0]  wp;
   logic [AW:0]  rp;
   logic         empty;
   logic         full;
   logic         pop;
   logic         do_push;
   logic         drop;

   assign empty   = (wp == rp);
   assign full    = (wp[AW] != rp[AW]) &&
                    (wp[AW-1:0] == rp[AW-1:0]);
   assign pop     = valid && ready;
   // A pop in the same clk frees a slot, so the push still lands.
   assign do_push = push && (!full || pop);
   assign drop    = push && full && !pop;

   assign valid = !empty;
   assign data  = valid ? mem[rp[AW-1:0]] : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wp  <= '0;
         rp  <= '0;
         ovf <= 1'b0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (pop) rp <= rp + (AW+1)'(1);
         if (do_push) begin
            mem[wp[AW-1:0]] <= push_data;
            wp <= wp + (AW+1)'(1);
         end
         // A drop outranks a clear in the same clk.
         if (drop)         ovf <= 1'b1;
         else if (ovf_clr) ovf <= 1'b0;
      end
   end

endmodule

// File: rtl/kp_matrix_scanner.sv
// kp_matrix_scanner: active-low ROWSxCOLS keypad scan, debounce, event FIFO.
// Ports: clk, rst, tick, row, col, key, frame, ev_*, ovf, ovf_clr.
// Optional auto-repeat when KP_AUTOREPEAT_EN is defined.
module kp_matrix_scanner
   import kp_pkg::*;
#(
   parameter int ROWS       = 4,
   parameter int COLS       = 4,
   parameter int DEB_FRAMES = 3,
   parameter int FIFO_DEPTH = 4,
   parameter int REP_DELAY  = 50,
   parameter int REP_PERIOD = 10
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            tick,
   input  logic [ROWS-1:0]                 row,
   output logic [COLS-1:0]                 col,
   output logic [ROWS*COLS-1:0]            key,
   output logic                            frame,
   output logic                            ev_valid,
   input  logic                            ev_ready,
   output logic [ev_idx_w(ROWS*COLS)+1:0]  ev_data,
   output logic                            ovf,
   input  logic                            ovf_clr
);

   localparam int N  = ROWS * COLS;
   localparam int IW = ev_idx_w(N);
   localparam int EW = IW + EV_FLAG_W;
   localparam int CW = kp_clog2(COLS);

   if (DEB_FRAMES < 1 || DEB_FRAMES > 15 ||
       REP_DELAY < 1 || REP_PERIOD < 1) begin : g_bad_param
      $error("kp_matrix_scanner: parameter out of range");
   end

   state_t          state;
   logic [CW-1:0]   c;
   logic [IW-1:0]   k;
   logic            pend;
   logic [COLS-1:0] raw_r [ROWS];
   logic [N-1:0]    raw;
   logic [3:0]      cnt [N];

   logic            diff;
   logic            deb_hit;
   logic [3:0]      cnt_nx;
   logic            push;
   logic [EW-1:0]   push_data;

   always_comb begin
      raw = '0;
      for (int r = 0; r < ROWS; r++) raw[r*COLS +: COLS] = raw_r[r];
   end

   assign diff    = (raw[k] != key[k]);
   assign cnt_nx  = cnt[k] + 4'd1;
   assign deb_hit = (state == UPDATE) && diff &&
                    (cnt_nx == 4'(DEB_FRAMES));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= DRIVE;
         c     <= '0;
         k     <= '0;
         pend  <= 1'b0;
         col   <= '1;
         key   <= '0;
         frame <= 1'b0;
         for (int r = 0; r < ROWS; r++) raw_r[r] <= '0;
         for (int i = 0; i < N; i++) cnt[i] <= '0;
      end else begin
         frame <= 1'b0;
         unique case (state)
            DRIVE: begin
               // A tick seen during UPDATE is spent here.
               if (tick || pend) begin
                  pend  <= 1'b0;
                  col   <= ~(COLS'(1) << c);
                  state <= SAMPLE;
               end
            end
            SAMPLE: begin
               if (tick) begin
                  for (int r = 0; r < ROWS; r++)
                     raw_r[r][c] <= ~row[r];
                  if (c == CW'(COLS-1)) begin
                     c     <= '0;
                     k     <= '0;
                     state <= UPDATE;
                  end else begin
                     c     <= c + CW'(1);
                     state <= DRIVE;
                  end
               end
            end
            UPDATE: begin
               if (tick) pend <= 1'b1;
               if (!diff) begin
                  cnt[k] <= '0;
               end else if (deb_hit) begin
                  cnt[k] <= '0;
                  key[k] <= raw[k];
               end else begin
                  cnt[k] <= cnt_nx;
               end
               if (k == IW'(N-1)) begin
                  state <= DRIVE;
                  frame <= 1'b1;
               end else begin
                  k <= k + IW'(1);
               end
            end
            default: state <= DRIVE;
         endcase
      end
   end

`ifdef KP_AUTOREPEAT_EN
   logic          onehot;
   logic          same;
   logic          rep_hit;
   logic          armed;
   logic          rep_on;
   logic [IW-1:0] hot_idx;
   logic [IW-1:0] ridx;
   logic [7:0]    rcnt;
   logic [7:0]    rcnt_nx;

   always_comb begin
      hot_idx = '0;
      for (int i = N-1; i >= 0; i--)
         if (key[i]) hot_idx = IW'(i);
   end

   assign onehot  = (key != '0) && ((key & (key - N'(1))) == '0);
   assign same    = onehot && armed && (hot_idx == ridx);
   assign rcnt_nx = rcnt + 8'd1;
   // Evaluated on the frame clk, once the bitmap is final.
   assign rep_hit = frame && same &&
                    (rep_on ? (rcnt_nx == 8'(REP_PERIOD))
                            : (rcnt_nx == 8'(REP_DELAY)));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rcnt   <= '0;
         rep_on <= 1'b0;
         armed  <= 1'b0;
         ridx   <= '0;
      end else if (frame) begin
         if (same) begin
            if (rep_hit) begin
               rcnt   <= '0;
               rep_on <= 1'b1;
            end else begin
               rcnt <= rcnt_nx;
            end
         end else begin
            rcnt   <= '0;
            rep_on <= 1'b0;
            armed  <= onehot;
            ridx   <= hot_idx;
         end
      end
   end

   // Debounce pushes occur in UPDATE, repeats on the frame clk: no clash.
   assign push = deb_hit || rep_hit;

   always_comb begin
      push_data = '0;
      if (deb_hit) begin
         push_data[IW-1:0]       = k;
         push_data[IW+EV_PRESS]  = raw[k];
      end else begin
         push_data[IW-1:0]       = hot_idx;
         push_data[IW+EV_PRESS]  = 1'b1;
         push_data[IW+EV_REPEAT] = 1'b1;
      end
   end
`else
   assign push = deb_hit;

   always_comb begin
      push_data = '0;
      push_data[IW-1:0]       = k;
      push_data[IW+EV_PRESS]  = raw[k];
      push_data[IW+EV_REPEAT] = 1'b0;
   end
`endif

   kp_event_fifo #(
      .W     (EW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (push_data),
      .ovf_clr   (ovf_clr),
      .ready     (ev_ready),
      .valid     (ev_valid),
      .data      (ev_data),
      .ovf       (ovf)
   );

endmodule
